// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// The constants cover widths, the next-PC select encoding and HALT opcode detection.
package if_pkg;

    localparam int NB_DATA     = 32;
    localparam int N_ELEMENTS  = 128;
    localparam int ADDRWIDTH   = $clog2(N_ELEMENTS);
    localparam int LOCK_CYCLES = 8;

    typedef enum logic [1:0] {
        PC_NEXT   = 2'd0,
        PC_JUMP   = 2'd1,
        PC_REG    = 2'd2,
        PC_BRANCH = 2'd3
    } pc_src_e;

    localparam logic [5:0] OPCODE_HALT = 6'b111111;

    function automatic logic is_halt(input logic [NB_DATA-1:0] word);
        return (word[NB_DATA-1:NB_DATA-6] == OPCODE_HALT);
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// Single-clock instruction RAM with one write port and one registered read port.
// A read and a write to the same address on the same edge return the old word.
module instruction_memory
    import if_pkg::*;
#(
    parameter int NB_DATA    = if_pkg::NB_DATA,
    parameter int N_ELEMENTS = if_pkg::N_ELEMENTS,
    parameter int ADDRWIDTH  = if_pkg::ADDRWIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDRWIDTH-1:0] wr_addr,
    input  logic [NB_DATA-1:0]   wr_data,
    input  logic                 rd_en,
    input  logic [ADDRWIDTH-1:0] rd_addr,
    output logic [NB_DATA-1:0]   rd_data
);

    logic [NB_DATA-1:0] mem_r [N_ELEMENTS];

    // Storage array; contents deliberately survive every reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port doubling as the instruction register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/top_if.sv
// Instruction-fetch stage: PC, next-PC selection, instruction memory, HALT flag
// and a clock-lock model that holds off all fetch activity until the clock is stable.
module top_if
    import if_pkg::*;
#(
    parameter int NB_DATA     = if_pkg::NB_DATA,
    parameter int N_ELEMENTS  = if_pkg::N_ELEMENTS,
    parameter int ADDRWIDTH   = $clog2(N_ELEMENTS),
    parameter int LOCK_CYCLES = if_pkg::LOCK_CYCLES
) (
    input  logic                 clock_i,
    input  logic                 reset_wz_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 debug_unit_i,
    input  logic [ADDRWIDTH-1:0] wr_addr_i,
    input  logic [NB_DATA-1:0]   instruction_i,
    input  logic [1:0]           pc_src_i,
    input  logic [ADDRWIDTH-1:0] addr_jump_i,
    input  logic [ADDRWIDTH-1:0] addr_register_i,
    input  logic [ADDRWIDTH-1:0] addr_branch_i,
    input  logic                 en_read_i,
    input  logic                 en_write_i,
    output logic [NB_DATA-1:0]   instruction_o,
    output logic [ADDRWIDTH-1:0] pc_o,
    output logic                 halt_o,
    output logic                 locked_o
);

    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    logic [LOCK_W-1:0]    lock_cnt_r;
    logic                 locked_r;
    logic [ADDRWIDTH-1:0] pc_r;
    logic [ADDRWIDTH-1:0] next_pc_s;
    logic [ADDRWIDTH-1:0] rd_addr_s;
    logic                 halt_seen_r;
    logic                 pc_en_s;
    logic                 wr_en_s;
    logic                 rd_en_s;

    // Nothing in the stage moves until the clock model reports lock.
    assign pc_en_s   = locked_r & enable_i & ~debug_unit_i & ~halt_o;
    assign wr_en_s   = locked_r & debug_unit_i & en_write_i;
    assign rd_en_s   = locked_r & en_read_i;
    assign rd_addr_s = debug_unit_i ? wr_addr_i : pc_r;

    // Next-PC selection; sequential fetch wraps naturally at the top of memory.
    always_comb begin
        next_pc_s = pc_r + ADDRWIDTH'(1);
        case (pc_src_e'(pc_src_i))
            PC_NEXT:   next_pc_s = pc_r + ADDRWIDTH'(1);
            PC_JUMP:   next_pc_s = addr_jump_i;
            PC_REG:    next_pc_s = addr_register_i;
            PC_BRANCH: next_pc_s = addr_branch_i;
            default:   next_pc_s = pc_r + ADDRWIDTH'(1);
        endcase
    end

    // Lock counter: counts edges after the wizard reset releases, then latches lock.
    always_ff @(posedge clock_i or posedge reset_wz_i) begin
        if (reset_wz_i) begin
            lock_cnt_r <= '0;
            locked_r   <= 1'b0;
        end else if (!locked_r) begin
            if (lock_cnt_r == LOCK_LAST) begin
                locked_r <= 1'b1;
            end else begin
                lock_cnt_r <= lock_cnt_r + LOCK_W'(1);
            end
        end
    end

    // Program counter.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            pc_r <= '0;
        end else if (pc_en_s) begin
            pc_r <= next_pc_s;
        end
    end

    // Sticky memory of a HALT word having been loaded, kept after the register moves on.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            halt_seen_r <= 1'b0;
        end else begin
            halt_seen_r <= halt_seen_r | is_halt(instruction_o);
        end
    end

    instruction_memory #(
        .NB_DATA    (NB_DATA),
        .N_ELEMENTS (N_ELEMENTS),
        .ADDRWIDTH  (ADDRWIDTH)
    ) u_imem (
        .clock   (clock_i),
        .reset   (reset_i),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_i),
        .wr_data (instruction_i),
        .rd_en   (rd_en_s),
        .rd_addr (rd_addr_s),
        .rd_data (instruction_o)
    );

    // HALT is visible in the same edge that loads it, then held by halt_seen_r.
    assign halt_o   = halt_seen_r | is_halt(instruction_o);
    assign pc_o     = pc_r;
    assign locked_o = locked_r;

endmodule

// File: tb/tb_top_if.sv
// Self-checking bench for top_if: directed scenarios followed by randomized
// traffic, all compared against a behavioural fetch-stage model.
module tb_top_if;

    localparam int NB = 32;
    localparam int AW = 7;
    localparam int NE = 128;
    localparam int LK = 8;

    logic          clock_i = 1'b0;
    logic          reset_wz_i, reset_i, enable_i, debug_unit_i;
    logic [AW-1:0] wr_addr_i, addr_jump_i, addr_register_i, addr_branch_i;
    logic [NB-1:0] instruction_i;
    logic [1:0]    pc_src_i;
    logic          en_read_i, en_write_i;
    logic [NB-1:0] instruction_o;
    logic [AW-1:0] pc_o;
    logic          halt_o, locked_o;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    logic [NB-1:0] mem_m [NE];
    int            pc_m;
    logic [NB-1:0] instr_m;
    bit            halt_m;
    bit            lock_m;
    int            lcnt_m;

    top_if dut (
        .clock_i         (clock_i),
        .reset_wz_i      (reset_wz_i),
        .reset_i         (reset_i),
        .enable_i        (enable_i),
        .debug_unit_i    (debug_unit_i),
        .wr_addr_i       (wr_addr_i),
        .instruction_i   (instruction_i),
        .pc_src_i        (pc_src_i),
        .addr_jump_i     (addr_jump_i),
        .addr_register_i (addr_register_i),
        .addr_branch_i   (addr_branch_i),
        .en_read_i       (en_read_i),
        .en_write_i      (en_write_i),
        .instruction_o   (instruction_o),
        .pc_o            (pc_o),
        .halt_o          (halt_o),
        .locked_o        (locked_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_value({tag, ".pc"},     32'(pc_o),     32'(pc_m));
        check_value({tag, ".instr"},  instruction_o, instr_m);
        check_value({tag, ".halt"},   32'(halt_o),   32'(halt_m));
        check_value({tag, ".locked"}, 32'(locked_o), 32'(lock_m));
    endtask

    // One clock edge: advance the model from the rules, then compare everything.
    task automatic step(input string tag);
        int            rd;
        logic [NB-1:0] old_word;
        bit            was_locked;
        bit            was_halted;
        int            nxt;
        @(posedge clock_i);
        #1;
        was_locked = lock_m;
        was_halted = halt_m;
        if (!lock_m) begin
            lcnt_m++;
            if (lcnt_m == LK) lock_m = 1'b1;
        end
        if (was_locked) begin
            rd = debug_unit_i ? int'(wr_addr_i) : pc_m;
            old_word = mem_m[rd];
            if (debug_unit_i && en_write_i) mem_m[wr_addr_i] = instruction_i;
            if (en_read_i) begin
                instr_m = old_word;
                if (old_word[31:26] == 6'd63) halt_m = 1'b1;
            end
            if (enable_i && !debug_unit_i && !was_halted) begin
                if (pc_src_i == 2'd1)      nxt = addr_jump_i;
                else if (pc_src_i == 2'd2) nxt = addr_register_i;
                else if (pc_src_i == 2'd3) nxt = addr_branch_i;
                else                       nxt = (pc_m + 1) % NE;
                pc_m = nxt;
            end
        end
        check_all(tag);
    endtask

    task automatic pulse_reset(input string tag);
        reset_i = 1'b1;
        #1;
        pc_m = 0; instr_m = '0; halt_m = 1'b0;
        check_all(tag);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic pulse_wz(input string tag);
        reset_wz_i = 1'b1;
        #1;
        lock_m = 1'b0; lcnt_m = 0;
        check_value({tag, ".locked"}, 32'(locked_o), 32'd0);
        #1;
        reset_wz_i = 1'b0;
    endtask

    task automatic set_run(input logic [1:0] src);
        debug_unit_i = 1'b0; enable_i = 1'b1; en_read_i = 1'b1;
        en_write_i = 1'b0; pc_src_i = src;
    endtask

    logic [NB-1:0] prog [3];
    logic [NB-1:0] w;
    logic [NB-1:0] saved5;

    initial begin
        prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0003; prog[2] = 32'hFC00_0000;
        reset_wz_i = 1'b1; reset_i = 1'b1;
        enable_i = 1'b0; debug_unit_i = 1'b0; wr_addr_i = '0; instruction_i = '0;
        pc_src_i = 2'd0; addr_jump_i = '0; addr_register_i = '0; addr_branch_i = '0;
        en_read_i = 1'b0; en_write_i = 1'b0;
        pc_m = 0; instr_m = '0; halt_m = 1'b0; lock_m = 1'b0; lcnt_m = 0;
        for (int i = 0; i < NE; i++) mem_m[i] = '0;
        #1;
        check_all("reset");
        #2;
        reset_wz_i = 1'b0; reset_i = 1'b0;

        // lock: exactly LK edges after release
        for (int i = 0; i < LK; i++) begin
            step("lock");
            check_value("lock_edge", 32'(locked_o), (i == LK - 1) ? 32'd1 : 32'd0);
        end

        // fill the whole memory so every later read is defined
        debug_unit_i = 1'b1; en_write_i = 1'b1; en_read_i = 1'b0;
        for (int a = 0; a < NE; a++) begin
            w = $urandom;
            if (w[31:26] == 6'd63) w[31] = 1'b0;
            if (a < 3) w = prog[a];
            wr_addr_i = AW'(a); instruction_i = w;
            step("fill");
        end

        // debug readback
        en_write_i = 1'b0; en_read_i = 1'b1;
        for (int a = 0; a < 3; a++) begin
            wr_addr_i = AW'(a);
            step("readback");
            check_value("readback_word", instruction_o, prog[a]);
            check_value("readback_pc", 32'(pc_o), 32'd0);
        end
        pulse_reset("clr_after_load");

        // sequential run to HALT
        set_run(2'd0);
        for (int i = 0; i < 3; i++) begin
            step("run");
            check_value("run_word", instruction_o, prog[i]);
        end
        check_value("run_halt", 32'(halt_o), 32'd1);
        check_value("run_halt_pc", 32'(pc_o), 32'd3);
        step("halted");
        step("halted");
        check_value("halt_pc_frozen", 32'(pc_o), 32'd3);
        check_value("halt_sticky", 32'(halt_o), 32'd1);

        // redirects and wrap
        pulse_reset("clr_before_redirect");
        addr_jump_i = 7'h40; addr_register_i = 7'h10; addr_branch_i = 7'h7F;
        set_run(2'd1); step("jump");   check_value("jump_pc", 32'(pc_o), 32'h40);
        set_run(2'd2); step("reg");    check_value("reg_pc", 32'(pc_o), 32'h10);
        set_run(2'd3); step("branch"); check_value("branch_pc", 32'(pc_o), 32'h7F);
        set_run(2'd0); step("wrap");   check_value("wrap_pc", 32'(pc_o), 32'h00);

        // stall
        enable_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("stall");
            check_value("stall_pc", 32'(pc_o), 32'h00);
        end

        // reset mid-run and re-run
        set_run(2'd0);
        step("mid1"); step("mid2");
        check_value("mid_pc", 32'(pc_o), 32'd2);
        pulse_reset("mid_reset");
        for (int i = 0; i < 3; i++) begin
            step("rerun");
            check_value("rerun_word", instruction_o, prog[i]);
        end

        // writes before lock are ignored
        pulse_reset("clr_before_relock");
        saved5 = mem_m[5];
        pulse_wz("relock");
        debug_unit_i = 1'b1; en_write_i = 1'b1; en_read_i = 1'b1;
        wr_addr_i = 7'd5; instruction_i = ~saved5;
        for (int i = 0; i < LK; i++) step("prelock");
        en_write_i = 1'b0;
        step("postlock_read");
        check_value("prelock_write_blocked", instruction_o, saved5);

        // same-address write and read in one edge returns the old word
        en_write_i = 1'b1; instruction_i = 32'h1234_5678;
        step("rdw");
        check_value("rdw_old", instruction_o, saved5);
        en_write_i = 1'b0;
        step("rdw_new");
        check_value("rdw_new_word", instruction_o, 32'h1234_5678);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                pulse_reset("rnd_reset");
            end else if (r < 4) begin
                pulse_wz("rnd_wz");
            end else begin
                debug_unit_i = ($urandom_range(0, 99) < 30);
                en_write_i = $urandom_range(0, 1);
                enable_i = ($urandom_range(0, 99) < 80);
                en_read_i = ($urandom_range(0, 99) < 80);
                pc_src_i = 2'($urandom_range(0, 3));
                wr_addr_i = AW'($urandom);
                addr_jump_i = AW'($urandom);
                addr_register_i = AW'($urandom);
                addr_branch_i = AW'($urandom);
                w = $urandom;
                if ($urandom_range(0, 99) < 10) w[31:26] = 6'd63;
                instruction_i = w;
                step("rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
